// File: rtl/grid_ctrl_axil_pkg.sv
// Shared types and constants for the grid controller AXI4-Lite register slave.
package grid_ctrl_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         N_REGS      = 4;

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_IDX  = 2'd1,
    REG_DATA = 2'd2,
    REG_AUX  = 2'd3
  } reg_idx_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  function automatic logic [N_REGS-1:0] reg_onehot(input reg_idx_e idx);
    logic [N_REGS-1:0] oh;
    case (idx)
      REG_CTRL: oh = 4'b0001;
      REG_IDX:  oh = 4'b0010;
      REG_DATA: oh = 4'b0100;
      REG_AUX:  oh = 4'b1000;
      default:  oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/grid_ctrl_strb_merge.sv
// Byte-lane merge of a register's current value with incoming write data.
module grid_ctrl_strb_merge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   old_val,
  input  logic [DW-1:0]   new_val,
  input  logic [DW/8-1:0] strb,
  output logic [DW-1:0]   merged
);

  // Select each byte lane from the new data only where its strobe is set.
  always_comb begin
    merged = old_val;
    for (int k = 0; k < DW/8; k++) begin
      if (strb[k]) begin
        merged[8*k +: 8] = new_val[8*k +: 8];
      end else begin
        merged[8*k +: 8] = old_val[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/grid_ctrl_axil_slave.sv
// AXI4-Lite slave holding the four grid-controller registers, with parallel
// register outputs and per-register write pulses.
module grid_ctrl_axil_slave
  import grid_ctrl_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [N_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [N_REGS-1:0]                 reg_wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  logic [N_REGS-1:0][DW-1:0] slv_reg_r;
  logic [N_REGS-1:0][DW-1:0] merged_s;
  logic [N_REGS-1:0]         wr_pulse_r;

  wr_state_e     wstate_r;
  logic          aw_held_r;
  reg_idx_e      awidx_r;
  logic          w_held_r;
  logic [DW-1:0] wdata_r;
  logic [SW-1:0] wstrb_r;
  logic          bvalid_r;
  logic [1:0]    bresp_r;

  rd_state_e     rstate_r;
  logic          rvalid_r;
  logic [1:0]    rresp_r;
  logic [DW-1:0] rdata_r;

  logic          awready_s;
  logic          wready_s;
  logic          arready_s;
  logic          aw_have_s;
  logic          w_have_s;
  logic          commit_s;
  reg_idx_e      widx_s;
  reg_idx_e      ridx_s;
  logic [DW-1:0] wdata_s;
  logic [SW-1:0] wstrb_s;
  logic          unused_s;

  // Each channel is accepted once and then held until the write commits;
  // nothing new is taken while a write response is outstanding.
  assign awready_s = S_AXI_AWVALID && !aw_held_r && !bvalid_r;
  assign wready_s  = S_AXI_WVALID && !w_held_r && !bvalid_r;
  assign arready_s = S_AXI_ARVALID && (rstate_r == R_IDLE);
  assign aw_have_s = aw_held_r || awready_s;
  assign w_have_s  = w_held_r || wready_s;
  assign commit_s  = aw_have_s && w_have_s;
  assign widx_s    = aw_held_r ? awidx_r : reg_idx_e'(S_AXI_AWADDR[3:2]);
  assign wdata_s   = w_held_r ? wdata_r : S_AXI_WDATA;
  assign wstrb_s   = w_held_r ? wstrb_r : S_AXI_WSTRB;
  assign ridx_s    = reg_idx_e'(S_AXI_ARADDR[3:2]);
  assign unused_s  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  for (genvar g = 0; g < N_REGS; g++) begin : g_merge
    grid_ctrl_strb_merge #(.DW(DW)) u_merge (
      .old_val (slv_reg_r[g]),
      .new_val (wdata_s),
      .strb    (wstrb_s),
      .merged  (merged_s[g])
    );
  end

  // Write FSM: latch AW/W independently, commit when both present, then hold B.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_r   <= W_IDLE;
      aw_held_r  <= 1'b0;
      awidx_r    <= REG_CTRL;
      w_held_r   <= 1'b0;
      wdata_r    <= '0;
      wstrb_r    <= '0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      wr_pulse_r <= '0;
      slv_reg_r  <= '0;
    end else begin
      wr_pulse_r <= '0;
      case (wstate_r)
        W_IDLE: begin
          if (commit_s) begin
            slv_reg_r[widx_s] <= merged_s[widx_s];
            wr_pulse_r        <= reg_onehot(widx_s);
            bvalid_r          <= 1'b1;
            bresp_r           <= RESP_OKAY;
            aw_held_r         <= 1'b0;
            w_held_r          <= 1'b0;
            wstate_r          <= W_RESP;
          end else begin
            if (awready_s) begin
              aw_held_r <= 1'b1;
              awidx_r   <= reg_idx_e'(S_AXI_AWADDR[3:2]);
            end
            if (wready_s) begin
              w_held_r <= 1'b1;
              wdata_r  <= S_AXI_WDATA;
              wstrb_r  <= S_AXI_WSTRB;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_r <= 1'b0;
            wstate_r <= W_IDLE;
          end
        end
        default: begin
          bvalid_r <= 1'b0;
          wstate_r <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: capture the register at AR acceptance (pre-write value on a
  // same-cycle write) and hold it until the R handshake.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate_r <= R_IDLE;
      rvalid_r <= 1'b0;
      rresp_r  <= RESP_OKAY;
      rdata_r  <= '0;
    end else begin
      case (rstate_r)
        R_IDLE: begin
          if (S_AXI_ARVALID) begin
            rdata_r  <= slv_reg_r[ridx_s];
            rresp_r  <= RESP_OKAY;
            rvalid_r <= 1'b1;
            rstate_r <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_r <= 1'b0;
            rstate_r <= R_IDLE;
          end
        end
        default: begin
          rvalid_r <= 1'b0;
          rstate_r <= R_IDLE;
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_s;
  assign S_AXI_WREADY  = wready_s;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = arready_s;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RDATA   = rdata_r;
  assign reg_q         = slv_reg_r;
  assign reg_wr_pulse  = wr_pulse_r;

endmodule

// File: tb/tb_grid_ctrl_axil_slave.sv
// Self-checking bench for grid_ctrl_axil_slave: directed transfers plus a
// transaction-level register model compared every cycle.
module tb_grid_ctrl_axil_slave;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [3:0][31:0] reg_q;
  logic [3:0]  reg_wr_pulse;

  int checks = 0;
  int errors = 0;

  grid_ctrl_axil_slave dut (
    .ACLK(clk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: registers, one pending AW, one pending W, one B, one R.
  logic [31:0] m_reg [4];
  logic        m_aw_pend, m_w_pend, m_b_pend, m_r_pend;
  logic [1:0]  m_aw_idx;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb, m_pulse;

  always @(negedge clk) begin
    logic aw_acc, w_acc, ar_acc, b_done, r_done;
    #2;
    if (areset) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 32'd0;
      m_aw_pend = 1'b0; m_w_pend = 1'b0; m_b_pend = 1'b0; m_r_pend = 1'b0;
      m_rdata = 32'd0; m_pulse = 4'd0; m_aw_idx = 2'd0; m_wdata = 32'd0; m_wstrb = 4'd0;
    end
    aw_acc = awvalid && !m_aw_pend && !m_b_pend;
    w_acc  = wvalid && !m_w_pend && !m_b_pend;
    ar_acc = arvalid && !m_r_pend;
    b_done = m_b_pend && bready;
    r_done = m_r_pend && rready;
    for (int i = 0; i < 4; i++) chk($sformatf("mon_reg_q%0d", i), reg_q[i], m_reg[i]);
    chk("mon_wr_pulse", {28'd0, reg_wr_pulse}, {28'd0, m_pulse});
    chk("mon_bvalid", {31'd0, bvalid}, {31'd0, m_b_pend});
    chk("mon_rvalid", {31'd0, rvalid}, {31'd0, m_r_pend});
    chk("mon_rdata", rdata, m_rdata);
    chk("mon_awready", {31'd0, awready}, {31'd0, aw_acc});
    chk("mon_wready", {31'd0, wready}, {31'd0, w_acc});
    chk("mon_arready", {31'd0, arready}, {31'd0, ar_acc});
    if (m_b_pend) chk("mon_bresp", {30'd0, bresp}, 32'd0);
    if (m_r_pend) chk("mon_rresp", {30'd0, rresp}, 32'd0);
    if (!areset) begin
      if (r_done) m_r_pend = 1'b0;
      if (ar_acc) begin m_rdata = m_reg[araddr[3:2]]; m_r_pend = 1'b1; end
      if (b_done) m_b_pend = 1'b0;
      if (aw_acc) begin m_aw_pend = 1'b1; m_aw_idx = awaddr[3:2]; end
      if (w_acc) begin m_w_pend = 1'b1; m_wdata = wdata; m_wstrb = wstrb; end
      m_pulse = 4'd0;
      if (m_aw_pend && m_w_pend) begin
        for (int k = 0; k < 4; k++)
          if (m_wstrb[k]) m_reg[m_aw_idx][8*k +: 8] = m_wdata[8*k +: 8];
        m_pulse[m_aw_idx] = 1'b1;
        m_b_pend = 1'b1; m_aw_pend = 1'b0; m_w_pend = 1'b0;
      end
    end
  end

  // Starts and ends on a falling edge; AW issued at cycle aw_dly, W at w_dly.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input logic [3:0] exp_pulse);
    bit aw_ok = 1'b0, w_ok = 1'b0;
    int last = 0, cyc = 0;
    while (!(aw_ok && w_ok) && cyc < 40) begin
      if (cyc == aw_dly && !aw_ok) begin awaddr = addr; awvalid = 1'b1; end
      if (cyc == w_dly && !w_ok) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
      #1;
      if (awvalid && awready) begin aw_ok = 1'b1; last = cyc; end
      if (wvalid && wready) begin w_ok = 1'b1; last = cyc; end
      @(negedge clk);
      if (aw_ok) awvalid = 1'b0;
      if (w_ok) wvalid = 1'b0;
      cyc++;
    end
    if (!(aw_ok && w_ok)) begin
      chk("wr_accept_timeout", 32'd1, 32'd0);
      awvalid = 1'b0; wvalid = 1'b0;
    end else begin
      chk("wr_accept_cycle", last, (aw_dly > w_dly) ? aw_dly : w_dly);
      chk("wr_bvalid", {31'd0, bvalid}, 32'd1);
      chk("wr_bresp", {30'd0, bresp}, 32'd0);
      chk("wr_pulse", {28'd0, reg_wr_pulse}, {28'd0, exp_pulse});
      chk("wr_reg_q", reg_q[addr[3:2]], data & {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}}
                                        | reg_q[addr[3:2]] & ~{{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}});
      if (bready) @(negedge clk);
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
    araddr = addr; arvalid = 1'b1;
    #1;
    chk("rd_arready", {31'd0, arready}, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("rd_rvalid", {31'd0, rvalid}, 32'd1);
    chk("rd_rdata", rdata, exp);
    chk("rd_rresp", {30'd0, rresp}, 32'd0);
    if (rready) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    awaddr = 4'd0; araddr = 4'd0; wdata = 32'd0; wstrb = 4'd0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    #1;
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_pulse", {28'd0, reg_wr_pulse}, 32'd0);
    chk("rst_reg3", reg_q[3], 32'd0);
    @(negedge clk); @(negedge clk);
    areset = 1'b0;
    @(negedge clk);

    // Sequential write then readback
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 4'b0001);
    axi_write(4'h4, 32'h2, 4'hF, 0, 0, 4'b0010);
    axi_write(4'h8, 32'h3, 4'hF, 0, 0, 4'b0100);
    axi_write(4'hC, 32'h4, 4'hF, 0, 0, 4'b1000);
    axi_read(4'h0, 32'h1);
    axi_read(4'h4, 32'h2);
    axi_read(4'h8, 32'h3);
    axi_read(4'hC, 32'h4);
    axi_read(4'h7, 32'h2);

    // Byte strobes
    axi_write(4'h8, 32'hAABBCCDD, 4'hF, 0, 0, 4'b0100);
    axi_write(4'h8, 32'h11223344, 4'b0101, 0, 0, 4'b0100);
    axi_read(4'h8, 32'hAA22CC44);

    // Split AW/W in both orders
    axi_write(4'hC, 32'hDEADBEEF, 4'hF, 0, 3, 4'b1000);
    axi_write(4'h4, 32'h0BADF00D, 4'hF, 3, 0, 4'b0010);
    axi_read(4'hC, 32'hDEADBEEF);
    axi_read(4'h4, 32'h0BADF00D);

    // Write backpressure: second write blocked until B handshake
    bready = 1'b0;
    axi_write(4'h0, 32'hCAFE0001, 4'hF, 0, 0, 4'b0001);
    awaddr = 4'hC; awvalid = 1'b1; wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_bvalid", {31'd0, bvalid}, 32'd1);
      chk("bp_bresp", {30'd0, bresp}, 32'd0);
      chk("bp_awready", {31'd0, awready}, 32'd0);
      chk("bp_wready", {31'd0, wready}, 32'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_bvalid_drop", {31'd0, bvalid}, 32'd0);
    chk("bp_awready_after", {31'd0, awready}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp_second_commit", reg_q[3], 32'h5A5A5A5A);
    @(negedge clk);

    // Read backpressure
    rready = 1'b0;
    axi_read(4'h0, 32'hCAFE0001);
    araddr = 4'hC; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rbp_rvalid", {31'd0, rvalid}, 32'd1);
      chk("rbp_rdata", rdata, 32'hCAFE0001);
      chk("rbp_arready", {31'd0, arready}, 32'd0);
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    #1;
    chk("rbp_arready_after", {31'd0, arready}, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("rbp_second_rdata", rdata, 32'h5A5A5A5A);
    @(negedge clk);

    // Same-cycle write and read of the same register
    axi_write(4'h8, 32'h3, 4'hF, 0, 0, 4'b0100);
    awaddr = 4'h8; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h8; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("sim_rdata_old", rdata, 32'h3);
    chk("sim_reg_new", reg_q[2], 32'h55);
    @(negedge clk);
    axi_read(4'h8, 32'h55);

    // Reset while a write response is outstanding
    bready = 1'b0;
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 4'b0001);
    #3;
    areset = 1'b1;
    #1;
    chk("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
    for (int i = 0; i < 4; i++) chk("mid_rst_reg_q", reg_q[i], 32'd0);
    @(negedge clk); @(negedge clk);
    areset = 1'b0; bready = 1'b1;
    @(negedge clk);
    axi_write(4'h4, 32'h12345678, 4'hF, 0, 0, 4'b0010);
    axi_read(4'h4, 32'h12345678);
    axi_read(4'h0, 32'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
